// File: rtl/mem_instr_pkg.sv
// mem_instr_pkg: shared RiSC-16 widths and boot-image table (WORD_LEN, ADDR_LEN, boot_word)
package mem_instr_pkg;
  localparam int WORD_LEN = 16;
  localparam int ADDR_LEN = 16;
  localparam int BOOT_LEN = 6;
  localparam logic [WORD_LEN-1:0] BOOT_IMG [BOOT_LEN] = '{
    16'h2405, 16'h2803, 16'h0C82, 16'h8C0A, 16'hB00A, 16'hC07F
  };
  function automatic logic [WORD_LEN-1:0] boot_word(input int i);
    return (i < BOOT_LEN) ? BOOT_IMG[i] : '0;
  endfunction
endpackage

// File: rtl/mem_instr.sv
// mem_instr: instruction memory, comb read out=mem[addr] (NOP past depth), sync write wr_en/wr_addr/wr_data, rst reloads boot image
module mem_instr
  import mem_instr_pkg::*;
#(
  parameter int WORD_LEN  = mem_instr_pkg::WORD_LEN,
  parameter int ADDR_LEN  = mem_instr_pkg::ADDR_LEN,
  parameter int MEM_DEPTH = 256
) (
  output logic [WORD_LEN-1:0] out,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic                rst,
  input  logic                clk,
  input  logic                wr_en,
  input  logic [ADDR_LEN-1:0] wr_addr,
  input  logic [WORD_LEN-1:0] wr_data
);
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_LEN:0] DEPTH = MEM_DEPTH[ADDR_LEN:0];
  logic [WORD_LEN-1:0] r_mem [MEM_DEPTH];
  logic w_rd_ok, w_wr_ok;
  assign w_rd_ok = {1'b0, addr} < DEPTH;
  assign w_wr_ok = {1'b0, wr_addr} < DEPTH;
  assign out = w_rd_ok ? r_mem[addr[AW-1:0]] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= WORD_LEN'(boot_word(i));
    end else if (wr_en && w_wr_ok) begin
      r_mem[wr_addr[AW-1:0]] <= wr_data;
    end
  end
endmodule

// File: tb/tb_mem_instr.sv
// tb_mem_instr: directed self-checking bench for mem_instr
module tb_mem_instr;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] addr = '0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] out;
  logic [15:0] exp_mem [256];
  int n_cmp = 0;
  int n_bad = 0;

  mem_instr dut (
    .out(out), .addr(addr), .rst(rst), .clk(clk),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic load_boot_model();
    for (int i = 0; i < 256; i++) exp_mem[i] = 16'h0000;
    exp_mem[0] = 16'h2405;
    exp_mem[1] = 16'h2803;
    exp_mem[2] = 16'h0C82;
    exp_mem[3] = 16'h8C0A;
    exp_mem[4] = 16'hB00A;
    exp_mem[5] = 16'hC07F;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    edge_step();
    edge_step();
    @(negedge clk);
    rst = 1'b0;
    load_boot_model();
    for (int a = 0; a < 100; a++) begin
      addr = 16'(a);
      #1;
      n_cmp++;
      if (out !== exp_mem[a]) begin
        n_bad++;
        $display("FAIL reset_sweep addr=%0d got=%h want=%h", a, out, exp_mem[a]);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] oor [3];
    oor[0] = 16'd300;
    oor[1] = 16'd256;
    oor[2] = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      addr = oor[k];
      #1;
      n_cmp++;
      if (out !== 16'h0000) begin
        n_bad++;
        $display("FAIL oor_read addr=%0d got=%h want=0000", oor[k], out);
      end
    end
    addr = 16'd255;
    #1;
    n_cmp++;
    if (out !== 16'h0000) begin
      n_bad++;
      $display("FAIL last_word got=%h want=0000", out);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    addr = 16'd7;
    #1;
    n_cmp++;
    if (out !== 16'h0000) begin
      n_bad++;
      $display("FAIL wr_before got=%h want=0000", out);
    end
    wr_en = 1'b1;
    wr_addr = 16'd7;
    wr_data = 16'hABCD;
    edge_step();
    wr_en = 1'b0;
    exp_mem[7] = 16'hABCD;
    n_cmp++;
    if (out !== 16'hABCD) begin
      n_bad++;
      $display("FAIL wr_after got=%h want=abcd", out);
    end
  endtask

  task automatic test_reset_discards();
    @(negedge clk);
    addr = 16'd0;
    wr_en = 1'b1;
    wr_addr = 16'd0;
    wr_data = 16'h1234;
    edge_step();
    wr_en = 1'b0;
    n_cmp++;
    if (out !== 16'h1234) begin
      n_bad++;
      $display("FAIL wr_word0 got=%h want=1234", out);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out !== 16'h1234) begin
      n_bad++;
      $display("FAIL rst_between_edges got=%h want=1234", out);
    end
    edge_step();
    rst = 1'b0;
    load_boot_model();
    n_cmp++;
    if (out !== 16'h2405) begin
      n_bad++;
      $display("FAIL rst_restore0 got=%h want=2405", out);
    end
    addr = 16'd7;
    #1;
    n_cmp++;
    if (out !== 16'h0000) begin
      n_bad++;
      $display("FAIL rst_restore7 got=%h want=0000", out);
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    addr = 16'd2;
    rst = 1'b1;
    wr_en = 1'b1;
    wr_addr = 16'd2;
    wr_data = 16'hFFFF;
    edge_step();
    rst = 1'b0;
    wr_en = 1'b0;
    n_cmp++;
    if (out !== 16'h0C82) begin
      n_bad++;
      $display("FAIL rst_over_wr got=%h want=0c82", out);
    end
  endtask

  task automatic test_oor_write();
    @(negedge clk);
    exp_mem[9] = 16'h9999;
    wr_en = 1'b1;
    wr_addr = 16'd9;
    wr_data = 16'h9999;
    @(negedge clk);
    wr_addr = 16'd256;
    wr_data = 16'h5555;
    @(negedge clk);
    wr_addr = 16'd300;
    @(negedge clk);
    wr_addr = 16'hFFFF;
    @(negedge clk);
    wr_en = 1'b0;
    for (int a = 0; a < 256; a++) begin
      addr = 16'(a);
      #1;
      n_cmp++;
      if (out !== exp_mem[a]) begin
        n_bad++;
        $display("FAIL oor_write_sweep addr=%0d got=%h want=%h", a, out, exp_mem[a]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_out_of_range();
    test_write_read();
    test_reset_discards();
    test_reset_priority();
    test_oor_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
